// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM controller: FSM states, widths and the
// byte-address to SRAM-word mapping.
package mem_ctrl_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StLow,
      StHigh,
      StDone
   } state_e;

   localparam logic [31:0] BASE_ADDR_DEFAULT = 32'd1024;
   localparam int unsigned SRAM_DW           = 16;

   // Wrap-around subtraction; the low two byte-offset bits fall away in the shift.
   function automatic logic [31:0] map_word(input logic [31:0] byte_addr,
                                            input logic [31:0] base);
      map_word = (byte_addr - base) >> 2;
   endfunction

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable 3-bit down-counter timing each half-word phase; last flags the phase's
// final (address-hold) cycle.
module sram_wait_counter (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic       dec,
   input  logic [2:0] load_val,
   output logic       last
);

   logic [2:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load) begin
         count_d = load_val;
      end else if (dec && (count_q != 3'd0)) begin
         count_d = count_q - 3'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= 3'd0;
      end else begin
         count_q <= count_d;
      end
   end

   assign last = (count_q == 3'd0);

endmodule

// File: rtl/sram_mem_controller.sv
// Splits 32-bit MEM-stage loads/stores into two 16-bit SRAM phases with wait states.
// Optional one-entry last-read cache enabled by defining SRAM_LAST_READ_CACHE_EN.
module sram_mem_controller
   import mem_ctrl_pkg::*;
#(
   parameter int unsigned WAIT_CYCLES = 1,
   parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEFAULT,
   parameter int unsigned SRAM_AW     = 18
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mem_r_en,
   input  logic               mem_w_en,
   input  logic [31:0]        alu_res,
   input  logic [31:0]        Val_Rm,
   output logic [31:0]        res_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [SRAM_DW-1:0] sram_dq_out,
   input  logic [SRAM_DW-1:0] sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n
);

   localparam int unsigned WordW    = SRAM_AW - 1;
   localparam logic [2:0]  WaitLoad = 3'(WAIT_CYCLES);
   localparam bit          ZeroWait = (WAIT_CYCLES == 0);

   state_e           state_q, state_d;
   logic [WordW-1:0] word_q;
   logic [31:0]      data_q;
   logic             is_store_q;

   logic             req, req_store, req_hit;
   logic [WordW-1:0] req_word;
   logic             cnt_load, cnt_dec, cnt_last;
   logic             strobe;
   logic             cache_hit;
   logic [31:0]      cache_rdata;

   assign req       = mem_r_en | mem_w_en;
   assign req_store = mem_w_en;
   assign req_word  = WordW'(map_word(alu_res, BASE_ADDR));
   assign req_hit   = ~req_store & cache_hit;

   // Strobe drops in the final cycle of each phase so we_n rises before the address moves.
   assign strobe = is_store_q & (ZeroWait | ~cnt_last);

   sram_wait_counter u_wait_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (WaitLoad),
      .last     (cnt_last)
   );

   always_comb begin
      state_d     = state_q;
      ready       = 1'b0;
      cnt_load    = 1'b0;
      cnt_dec     = 1'b0;
      sram_addr   = '0;
      sram_dq_out = '0;
      sram_dq_oe  = 1'b0;
      sram_we_n   = 1'b1;
      res_data    = '0;
      unique case (state_q)
         StIdle: begin
            ready = ~req;
            if (req) begin
               cnt_load = 1'b1;
               state_d  = req_hit ? StDone : StLow;
            end
         end
         StLow: begin
            sram_addr  = {word_q, 1'b0};
            sram_dq_oe = strobe;
            sram_we_n  = ~strobe;
            if (is_store_q) begin
               sram_dq_out = data_q[15:0];
            end
            if (cnt_last) begin
               cnt_load = 1'b1;
               state_d  = StHigh;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StHigh: begin
            sram_addr  = {word_q, 1'b1};
            sram_dq_oe = strobe;
            sram_we_n  = ~strobe;
            if (is_store_q) begin
               sram_dq_out = data_q[31:16];
            end
            if (cnt_last) begin
               state_d = StDone;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StDone: begin
            ready   = 1'b1;
            state_d = StIdle;
            if (!is_store_q) begin
               res_data = data_q;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         word_q     <= '0;
         data_q     <= '0;
         is_store_q <= 1'b0;
      end else begin
         state_q <= state_d;
         if ((state_q == StIdle) && req) begin
            word_q     <= req_word;
            is_store_q <= req_store;
            data_q     <= req_hit ? cache_rdata : Val_Rm;
         end else if (!is_store_q && cnt_last) begin
            if (state_q == StLow) begin
               data_q[15:0] <= sram_dq_in;
            end
            if (state_q == StHigh) begin
               data_q[31:16] <= sram_dq_in;
            end
         end
      end
   end

`ifdef SRAM_LAST_READ_CACHE_EN
   logic             cache_valid_q;
   logic [WordW-1:0] cache_tag_q;
   logic [31:0]      cache_data_q;

   assign cache_hit   = cache_valid_q & (cache_tag_q == req_word);
   assign cache_rdata = cache_data_q;

   // Updated only on completion so an abandoned access never pollutes the entry.
   always_ff @(posedge clk) begin
      if (rst) begin
         cache_valid_q <= 1'b0;
         cache_tag_q   <= '0;
         cache_data_q  <= '0;
      end else if (state_q == StDone) begin
         if (!is_store_q) begin
            cache_valid_q <= 1'b1;
            cache_tag_q   <= word_q;
            cache_data_q  <= data_q;
         end else if (cache_valid_q && (cache_tag_q == word_q)) begin
            cache_data_q <= data_q;
         end
      end
   end
`else
   assign cache_hit   = 1'b0;
   assign cache_rdata = '0;
`endif

endmodule

// File: tb/tb_sram_mem_controller.sv
// Randomized self-checking bench for sram_mem_controller against a word-level memory model
// and an asynchronous SRAM model.
module tb_sram_mem_controller;

   localparam int unsigned W    = 1;
   localparam int unsigned AW   = 18;
   localparam logic [31:0] BASE = 32'd1024;

   logic          clk = 1'b0;
   logic          rst;
   logic          mem_r_en, mem_w_en;
   logic [31:0]   alu_res, Val_Rm, res_data;
   logic          ready;
   logic [AW-1:0] sram_addr;
   logic [15:0]   sram_dq_out, sram_dq_in;
   logic          sram_dq_oe, sram_we_n;

   always #5 clk = ~clk;

   sram_mem_controller #(
      .WAIT_CYCLES (W),
      .BASE_ADDR   (BASE),
      .SRAM_AW     (AW)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .mem_r_en    (mem_r_en),
      .mem_w_en    (mem_w_en),
      .alu_res     (alu_res),
      .Val_Rm      (Val_Rm),
      .res_data    (res_data),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n)
   );

   // Asynchronous SRAM: combinational read, write while we_n is low.
   logic [15:0] sram_mem [0:(1<<AW)-1];
   assign sram_dq_in = sram_mem[sram_addr];
   always @(posedge clk) if (!sram_we_n) sram_mem[sram_addr] <= sram_dq_out;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [31:0] ref_mem [int];
   bit          cache_valid = 1'b0;
   logic [31:0] cache_word  = '0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic do_access(input bit wr, input bit rd, input logic [31:0] addr,
                            input logic [31:0] data);
      logic [31:0] word, exp_rd;
      bit          is_store, hit, strobe, done;
      int          lat, k, phase, j;
      word     = ((addr - BASE) >> 2) & 32'h1FFFF;
      is_store = wr;
      hit      = 1'b0;
`ifdef SRAM_LAST_READ_CACHE_EN
      hit = !is_store && cache_valid && (cache_word == word);
`endif
      lat    = hit ? 1 : 2 * W + 3;
      exp_rd = ref_mem.exists(word) ? ref_mem[word] : 32'h0;
      @(posedge clk); #1;
      mem_w_en = wr;
      mem_r_en = rd;
      alu_res  = addr;
      Val_Rm   = data;
      k        = 0;
      done     = 1'b0;
      while (!done) begin
         @(negedge clk);
         if (ready) begin
            check_eq("latency", k, lat);
            check_eq(is_store ? "st_res_data" : "ld_res_data", res_data,
                     is_store ? 32'h0 : exp_rd);
            check_eq("done_we_n", sram_we_n, 1'b1);
            done = 1'b1;
         end else if (k >= 40) begin
            check_eq("timeout_ready", ready, 1'b1);
            done = 1'b1;
         end else begin
            check_eq("busy_res_data", res_data, 32'h0);
            if (k == 0 || hit) begin
               check_eq("req_we_n", sram_we_n, 1'b1);
            end else begin
               phase  = (k - 1) / (W + 1);
               j      = (k - 1) % (W + 1);
               strobe = is_store && (W == 0 || j < W);
               check_eq("addr", sram_addr, (word << 1) | 32'(phase));
               check_eq("we_n", sram_we_n, !strobe);
               check_eq("dq_oe", sram_dq_oe, strobe);
               if (strobe) check_eq("dq_out", sram_dq_out, phase ? data[31:16] : data[15:0]);
            end
            k++;
         end
      end
      @(posedge clk); #1;
      mem_w_en = 1'b0;
      mem_r_en = 1'b0;
      if (is_store) begin
         ref_mem[word] = data;
      end else begin
         cache_valid = 1'b1;
         cache_word  = word;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a, d;
      int          op;
      for (int i = 0; i < (1 << AW); i++) sram_mem[i] = '0;
      rst      = 1'b1;
      mem_r_en = 1'b0;
      mem_w_en = 1'b0;
      alu_res  = '0;
      Val_Rm   = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_eq("rst_ready", ready, 1'b1);
      check_eq("rst_we_n", sram_we_n, 1'b1);
      check_eq("rst_dq_oe", sram_dq_oe, 1'b0);
      check_eq("rst_res_data", res_data, 32'h0);
      check_eq("rst_addr", sram_addr, 32'h0);
      check_eq("rst_dq_out", sram_dq_out, 32'h0);

      do_access(1'b1, 1'b0, 32'd1032, 32'hDEADBEEF);
      do_access(1'b0, 1'b1, 32'd1032, 32'h0);
      do_access(1'b1, 1'b1, 32'd1024, 32'h12345678);
      do_access(1'b0, 1'b1, 32'd1024, 32'h0);
      do_access(1'b1, 1'b0, 32'd1023, 32'hA5C3_0F1E);
      do_access(1'b0, 1'b1, 32'd1023, 32'h0);
      do_access(1'b0, 1'b1, 32'd1035, 32'h0);

      // Abandon a load in its high phase.
      @(posedge clk); #1;
      mem_r_en = 1'b1;
      alu_res  = 32'd1032;
      repeat (W + 3) @(negedge clk);
      check_eq("mid_ready", ready, 1'b0);
      check_eq("mid_addr", sram_addr, 32'd5);
      rst      = 1'b1;
      mem_r_en = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check_eq("mid_rst_ready", ready, 1'b1);
      check_eq("mid_rst_we_n", sram_we_n, 1'b1);
      check_eq("mid_rst_dq_oe", sram_dq_oe, 1'b0);
      check_eq("mid_rst_res_data", res_data, 32'h0);
      cache_valid = 1'b0;
      do_access(1'b0, 1'b1, 32'd1032, 32'h0);

      do_access(1'b0, 1'b1, 32'd1040, 32'h0);
      do_access(1'b0, 1'b1, 32'd1040, 32'h0);
      do_access(1'b1, 1'b0, 32'd1040, 32'h55AA55AA);
      do_access(1'b0, 1'b1, 32'd1040, 32'h0);

      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 2));
         a  = BASE - 32'd16 + 32'($urandom_range(0, 11)) * 32'd4 + 32'($urandom_range(0, 3));
         d  = $urandom;
         do_access(op != 0, op != 1, a, d);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- Sequences MEM-stage data accesses onto an off-chip 16-bit asynchronous SRAM, replacing the on-chip 64-word data array.
- Accepts one 32-bit load or store from the pipeline and splits it into two half-word SRAM phases with programmable wait states.
- Holds `ready` low so the hazard/freeze logic stalls every pipeline register until the access completes.

Parameters:
- WAIT_CYCLES, 1, extra SRAM cycles per half-word phase; each phase lasts WAIT_CYCLES+1 cycles; legal range 0..7.
- BASE_ADDR, 1024, byte address that maps to SRAM word 0.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  synchronous, active-high reset.
- mem_r_en  in  1  load request, held by the pipeline while ready=0.
- mem_w_en  in  1  store request, held by the pipeline while ready=0.
- alu_res  in  32  byte address from the EX stage.
- Val_Rm  in  32  store data.
- res_data  out  32  load result; valid only in the cycle ready=1 completes a load.
- ready  out  1  combinational; 0 means freeze the pipeline.
- sram_addr  out  SRAM_AW  half-word address.
- sram_dq_out  out  16  write data to the pad.
- sram_dq_in  in  16  read data from the pad.
- sram_dq_oe  out  1  1 drives sram_dq_out onto the bus.
- sram_we_n  out  1  active-low write strobe.

Behaviour:
- **Address mapping:**
  - word = (alu_res − BASE_ADDR) >> 2, using 32-bit wrap-around subtraction.
  - sram_addr = {word[SRAM_AW−2:0], phase}, where phase is 0 for the low half and 1 for the high half.
  - Upper word bits are silently truncated.
  - alu_res[1:0] are ignored.
- **Request priority:** mem_w_en has priority when both mem_w_en and mem_r_en are asserted; the access is treated as a store.
- **FSM states:** IDLE, LOW, HIGH, DONE.
- **IDLE:**
  - No request: ready=1.
  - Request present: ready=0. Latch address, Val_Rm and the op; go to LOW.
- **LOW:**
  - Lasts WAIT_CYCLES+1 cycles, counted by a 3-bit wait counter.
  - Drives the phase-0 address.
  - Store: sram_we_n=0 and dq_oe=1 in every cycle except the last; sram_dq_out = Val_Rm[15:0].
  - Load: capture sram_dq_in into data[15:0] at the end of the last cycle.
  - Then go to HIGH.
- **HIGH:** same as LOW, using phase 1 and bits [31:16]; then go to DONE.
- **DONE:**
  - Lasts one cycle; ready=1.
  - Load: res_data = assembled word.
  - Always returns to IDLE.
  - A request present in the following cycle is a new access.
- **Store strobe rule:** sram_we_n returns high for one cycle before the address changes. The final cycle of each phase is the address-hold cycle.
  - If WAIT_CYCLES=0, sram_we_n is low for the whole single cycle.
- **Latency:** ready=0 for 2·WAIT_CYCLES+3 cycles, counting from the request cycle; ready=1 in the next cycle.
- **Default outputs:** res_data=0 whenever not (DONE and load). sram_we_n=1 and dq_oe=0 outside store phases.
- **Reset values (synchronous):**
  - State: IDLE; wait counter and data registers: 0.
  - sram_we_n=1, dq_oe=0, sram_addr=0, sram_dq_out=0, res_data=0.
  - ready=1 if no request.
- **Reset mid-access:** the access is abandoned and no completion is signalled. A store may have partially written the low half; that is accepted.
- **Request dropped while busy:** illegal. The controller completes the latched access regardless.

Optional Feature:
- Macro: SRAM_LAST_READ_CACHE_EN.
- **With the macro:**
  - One-entry tag register plus valid bit holds the last loaded word index and its data.
  - A load in IDLE whose word index matches the tag goes directly IDLE→DONE: ready=0 in the request cycle, ready=1 next cycle, data served from the entry.
  - A store to the matching word updates the cached data.
  - A completed load to any word refills the entry.
  - Reset clears the valid bit.
- **Without the macro:** no tag logic; every load takes the full latency.

Decomposition:
- Shared package `mem_ctrl_pkg` holds:
  - the state enum (IDLE, LOW, HIGH, DONE);
  - BASE_ADDR_DEFAULT=1024 and the SRAM data width of 16;
  - the address-mapping function.
- One natural sub-module, `sram_wait_counter`: loadable 3-bit down-counter with a `last` flag, shared by both phases.

Test Plan:
- **Store:** rst 2 cycles, WAIT_CYCLES=1; mem_w_en, alu_res=1032, Val_Rm=0xDEADBEEF.
  - Expect sram_addr 4 then 5, with dq 0xBEEF then 0xDEAD.
  - Expect one we_n low pulse per phase; ready low 5 cycles, high on cycle 5.
- **Load after store:** mem_r_en, alu_res=1032 with the SRAM model holding the stored data.
  - Expect res_data=0xDEADBEEF exactly in the ready=1 cycle, and 0 otherwise.
- **Simultaneous requests:** mem_r_en and mem_w_en both set, alu_res=1024, Val_Rm=0x12345678.
  - Expect a store to addresses 0 and 1; res_data stays 0.
- **Wrap and misalignment:** alu_res=1023.
  - Expect word=0x3FFFFFFF truncated, so sram_addr = 0x3FFFE then 0x3FFFF.
  - alu_res=1035 must behave identically to 1032.
- **Reset mid-access:** assert rst during the HIGH phase of a load.
  - Next cycle expect IDLE, ready=1, we_n=1, dq_oe=0, res_data=0; a new request starts cleanly.
- **Cache, macro defined:**
  - Two consecutive loads to 1040: second load has ready low exactly 1 cycle.
  - A store of 0x55AA55AA to 1040 followed by a load: the load returns 0x55AA55AA in 1 cycle.
